vcore_vexe_input_buf: RTL and testbench
=======================================

# vcore_vexe_input_buf

Decoupling buffer between vcore issue and the vector execution units (VEXE int/fp lanes). It holds up to DEPTH decoded vector instruction packets, presents them in order to VEXE with a valid/ready handshake, and raises a near-full hint so issue can throttle early. It also tracks instructions dispatched to VEXE but not yet retired, and blocks dispatch at the outstanding limit.

## Interface
Parameters:
- DEPTH, 4, packet entries; power of two, ≥2 (VCORE_VEXE_INPUT_BUF_DEPTH).
- NEARFULL_THSHD, 2, occupancy at which nearfull asserts; 1..DEPTH (VCORE_VEXE_INPUT_BUF_NEARFULL_THSHD).
- PKT_W, 64, opaque packet width: opcode, vd/vs1/vs2 ids, scalar operand, vlen.
- OTS_CTR_W, 5, outstanding-counter width (VCORE_OTS_CTR_W); limit = 2^OTS_CTR_W − 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  issue presents a packet.
- in_ready  out  1  buffer accepts; = count != DEPTH and !flush.
- in_pkt  in  PKT_W  packet from issue.
- out_valid  out  1  head packet available to VEXE.
- out_ready  in  1  VEXE takes head.
- out_pkt  out  PKT_W  head packet; don't-care when out_valid=0.
- nearfull  out  1  count ≥ NEARFULL_THSHD.
- count  out  $clog2(DEPTH)+1  current occupancy.
- flush  in  1  synchronous discard of all buffered packets.
- retire  in  1  one dispatched instruction completed in VEXE.
- ots_cnt  out  OTS_CTR_W  dispatched-not-retired count.
- ots_err  out  1  sticky: retire seen with ots_cnt = 0.

## Operation
- Circular storage; rd_ptr/wr_ptr of $clog2(DEPTH) bits wrap DEPTH−1 → 0; count register kept separately.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = count != 0 & ots_cnt != limit & !flush.
- out_pkt driven directly from entry[rd_ptr] (show-ahead, no extra register).
- Per cycle: count += push − pop; both → count unchanged, both pointers advance.
- Full (count = DEPTH): in_ready = 0 even if pop occurs this cycle; no bypass.
- Empty: out_valid = 0; no input→output bypass in the same cycle.
- flush (priority over all FIFO updates): rd_ptr, wr_ptr, count ← 0 next cycle; in_ready and out_valid forced 0 during the flush cycle, so no push/pop occurs. Storage contents need not be cleared. ots_cnt and ots_err unaffected (already-dispatched instructions still retire).
- ots_cnt: +1 on pop, −1 on retire; both in the same cycle → unchanged. At the limit, out_valid is held 0 so it never overflows.
- retire with ots_cnt = 0: counter stays 0, ots_err ← 1, cleared only by reset. Retire with a simultaneous pop at 0: net unchanged, no error.
- nearfull and in_ready are combinational from count/flush; out_valid from count/ots_cnt/flush.

## Timing
- Reset (rstn low, async): rd_ptr = wr_ptr = 0, count = 0, ots_cnt = 0, ots_err = 0. Hence out_valid = 0, nearfull = 0 (NEARFULL_THSHD ≥ 1), in_ready = 1 unless flush is high. Storage is not reset.
- Latency: push at edge N → out_valid high after edge N (visible in cycle N+1), if ots_cnt below limit.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- nearfull reflects the registered count; it rises the cycle after the push that reaches the threshold.
- Reset asserted mid-operation discards all packets and the outstanding count immediately.

## Test plan
- Fill/drain: out_ready=0, push P0..P3 → in_ready=0 after 4th push, count=4, nearfull high from count=2; then out_ready=1 → P0..P3 out in order over 4 cycles, count returns to 0, ots_cnt=4.
- Full + simultaneous: count=4, in_valid=1, out_ready=1 → one pop, no push that cycle, count=3; next cycle push accepted, count=4.
- Wrap: 10 packets streamed at one per cycle with out_ready=1 → all 10 out in order, pointers wrap twice, count never exceeds 1.
- Flush: count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, no packet consumed or accepted; ots_cnt unchanged.
- Outstanding limit: OTS_CTR_W=5, 31 pops without retire → ots_cnt=31, out_valid=0 with count>0; one retire → ots_cnt=30, out_valid=1; same-cycle pop+retire → ots_cnt stays.
- Retire underflow: ots_cnt=0, retire=1 → ots_cnt=0, ots_err=1 and stays 1 until rstn low.

Source files
------------

// File: rtl/vcore_vexe_input_buf_if.sv
// Issue/VEXE-side bundle for the vector execution input buffer.
// The master modport is the environment (issue + VEXE); the slave modport is the buffer.
interface vcore_vexe_input_buf_if #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned PKT_W     = 64,
   parameter int unsigned OTS_CTR_W = 5
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   // Issue side
   logic             in_valid;
   logic             in_ready;
   logic [PKT_W-1:0] in_pkt;
   // VEXE side
   logic             out_valid;
   logic             out_ready;
   logic [PKT_W-1:0] out_pkt;
   // Status and control
   logic             nearfull;
   logic [CNT_W-1:0] count;
   logic             flush;
   logic             retire;
   logic [OTS_CTR_W-1:0] ots_cnt;
   logic             ots_err;

   modport master (
      output in_valid, in_pkt, out_ready, flush, retire,
      input  in_ready, out_valid, out_pkt, nearfull, count, ots_cnt, ots_err
   );

   modport slave (
      input  in_valid, in_pkt, out_ready, flush, retire,
      output in_ready, out_valid, out_pkt, nearfull, count, ots_cnt, ots_err
   );
endinterface

// File: rtl/vcore_vexe_input_buf.sv
// Decoupling buffer between vcore issue and the VEXE lanes: in-order show-ahead FIFO,
// near-full throttle hint, and a dispatched-but-not-retired counter that gates dispatch.
module vcore_vexe_input_buf #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned NEARFULL_THSHD = 2,
   parameter int unsigned PKT_W          = 64,
   parameter int unsigned OTS_CTR_W      = 5
) (
   input logic                      clk,
   input logic                      rstn,
   vcore_vexe_input_buf_if.slave    bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0]     CntOne   = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CntFull  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]     CntNear  = CNT_W'(NEARFULL_THSHD);
   localparam logic [PTR_W-1:0]     PtrOne   = PTR_W'(1);
   localparam logic [OTS_CTR_W-1:0] OtsOne   = OTS_CTR_W'(1);
   localparam logic [OTS_CTR_W-1:0] OtsLimit = '1;

   logic [PKT_W-1:0]     mem_q [DEPTH];
   logic [PKT_W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [OTS_CTR_W-1:0] ots_cnt_q, ots_cnt_d;
   logic                 ots_err_q, ots_err_d;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   // Handshake qualification: full blocks push even with a concurrent pop (no bypass),
   // and flush suppresses both sides for its cycle.
   always_comb begin
      in_ready  = (count_q != CntFull) && !bus.flush;
      out_valid = (count_q != '0) && (ots_cnt_q != OtsLimit) && !bus.flush;
      push      = bus.in_valid && in_ready;
      pop       = out_valid && bus.out_ready;
   end

   // Output drive: head entry shown directly from storage.
   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = out_valid;
      bus.out_pkt   = mem_q[rd_ptr_q];
      bus.nearfull  = count_q >= CntNear;
      bus.count     = count_q;
      bus.ots_cnt   = ots_cnt_q;
      bus.ots_err   = ots_err_q;
   end

   // Storage write on accepted push.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.in_pkt;
      end
   end

   // Pointer and occupancy next state; flush overrides any FIFO update.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 naturally.
         if (push) wr_ptr_d = wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
         unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   // Outstanding tracking: dispatch increments, retire decrements; an unmatched retire at zero
   // saturates and latches the error until reset.
   always_comb begin
      ots_cnt_d = ots_cnt_q;
      ots_err_d = ots_err_q;
      unique case ({pop, bus.retire})
         2'b10: ots_cnt_d = ots_cnt_q + OtsOne;
         2'b01: begin
            if (ots_cnt_q == '0) begin
               ots_err_d = 1'b1;
            end else begin
               ots_cnt_d = ots_cnt_q - OtsOne;
            end
         end
         default: ots_cnt_d = ots_cnt_q;
      endcase
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         ots_cnt_q <= '0;
         ots_err_q <= 1'b0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ots_cnt_q <= ots_cnt_d;
         ots_err_q <= ots_err_d;
      end
   end

   // Packet storage is not reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_vcore_vexe_input_buf.sv
// Directed bench for vcore_vexe_input_buf: reference occupancy/outstanding model plus a
// packet scoreboard queue filled on accepted pushes and drained on observed pops.
module tb_vcore_vexe_input_buf;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned NF        = 2;
   localparam int unsigned PKT_W     = 64;
   localparam int unsigned OTS_W     = 5;
   localparam int          OTS_LIMIT = 31;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   vcore_vexe_input_buf_if #(.DEPTH(DEPTH), .PKT_W(PKT_W), .OTS_CTR_W(OTS_W)) bus ();

   vcore_vexe_input_buf #(
      .DEPTH(DEPTH), .NEARFULL_THSHD(NF), .PKT_W(PKT_W), .OTS_CTR_W(OTS_W)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] sb_q[$];
   int          m_cnt;
   int          m_ots;
   logic        m_err;
   int          max_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_pkt    = '0;
      bus.out_ready = 1'b0;
      bus.flush     = 1'b0;
      bus.retire    = 1'b0;
   endtask

   // Asynchronous reset asserted away from the clock edge; state must clear at once.
   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rstn = 1'b0;
      #1;
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_nearfull", 64'(bus.nearfull), 64'd0);
      check("rst_ots_cnt", 64'(bus.ots_cnt), 64'd0);
      check("rst_ots_err", 64'(bus.ots_err), 64'd0);
      m_cnt = 0;
      m_ots = 0;
      m_err = 1'b0;
      sb_q.delete();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One clock of stimulus: drive, check against the model, then advance the model.
   task automatic cycle(input logic iv, input logic [63:0] pkt, input logic ordy,
                        input logic fl, input logic ret);
      logic exp_ir, exp_ov, push, pop;
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_pkt    = pkt;
      bus.out_ready = ordy;
      bus.flush     = fl;
      bus.retire    = ret;
      #1;
      exp_ir = (m_cnt != DEPTH) && !fl;
      exp_ov = (m_cnt != 0) && (m_ots != OTS_LIMIT) && !fl;
      check("count", 64'(bus.count), 64'(m_cnt));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
      check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      check("nearfull", 64'(bus.nearfull), 64'(m_cnt >= NF));
      check("ots_cnt", 64'(bus.ots_cnt), 64'(m_ots));
      check("ots_err", 64'(bus.ots_err), 64'(m_err));
      push = iv && exp_ir;
      pop  = exp_ov && ordy;
      if (pop) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_underrun observed=pop expected=no_pop");
         end else begin
            check("out_pkt", bus.out_pkt, sb_q.pop_front());
         end
      end
      if (push) sb_q.push_back(pkt);
      if (fl) begin
         m_cnt = 0;
         sb_q.delete();
      end else begin
         m_cnt = m_cnt + int'(push) - int'(pop);
      end
      if (pop && !ret) m_ots++;
      else if (ret && !pop) begin
         if (m_ots == 0) m_err = 1'b1;
         else m_ots--;
      end
      if (m_cnt > max_cnt) max_cnt = m_cnt;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      do_reset();

      // Fill with VEXE stalled, then the full + simultaneous pop/push case, then drain.
      for (int i = 0; i < 4; i++) cycle(1'b1, 64'hA000_0000_0000_0000 | 64'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'hA000_0000_0000_00FF, 1'b0, 1'b0, 1'b0);
      check("fill_count", 64'(bus.count), 64'd4);
      check("fill_in_ready", 64'(bus.in_ready), 64'd0);
      cycle(1'b1, 64'hA000_0000_0000_0004, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 64'hA000_0000_0000_0005, 1'b0, 1'b0, 1'b0);
      check("full_repush_count", 64'(bus.count), 64'd3);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain_count", 64'(bus.count), 64'd0);
      check("drain_ots", 64'(bus.ots_cnt), 64'd5);

      // Streaming with pointer wrap; occupancy should never exceed one.
      do_reset();
      max_cnt = 0;
      for (int i = 0; i < 10; i++) cycle(1'b1, {32'hB000_0000, $urandom}, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("wrap_max_count", 64'(max_cnt), 64'd1);
      check("wrap_ots", 64'(bus.ots_cnt), 64'd10);

      // Flush with handshakes attempted on both sides; outstanding count unaffected.
      for (int i = 0; i < 3; i++) cycle(1'b1, 64'hC000_0000_0000_0000 | 64'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 64'hC000_0000_0000_00EE, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("flush_count", 64'(bus.count), 64'd0);
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_ots", 64'(bus.ots_cnt), 64'd10);

      // Outstanding limit: stream until dispatch stalls at 31 with packets still buffered.
      do_reset();
      for (int i = 0; i < 34; i++) cycle(1'b1, 64'hD000_0000_0000_0000 | 64'(i), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("limit_ots", 64'(bus.ots_cnt), 64'd31);
      check("limit_out_valid", 64'(bus.out_valid), 64'd0);
      check("limit_count_nz", 64'(bus.count != 0), 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("limit_retire_ots", 64'(bus.ots_cnt), 64'd30);
      check("limit_retire_ov", 64'(bus.out_valid), 64'd1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("pop_retire_ots", 64'(bus.ots_cnt), 64'd30);

      // Mid-operation reset, then pop+retire at zero (no error), then true underflow.
      do_reset();
      cycle(1'b1, 64'hE000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("pop_retire_zero_err", 64'(bus.ots_err), 64'd0);
      check("pop_retire_zero_ots", 64'(bus.ots_cnt), 64'd0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("underflow_err", 64'(bus.ots_err), 64'd1);
      check("underflow_ots", 64'(bus.ots_cnt), 64'd0);
      cycle(1'b1, 64'hE000_0000_0000_0002, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("err_sticky", 64'(bus.ots_err), 64'd1);
      do_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
